gt_drp_multi: RTL

Parametrised multi-channel DRP master for transceiver configuration, the successor to the single-channel DRP bridge. It takes 64-bit host register writes and runs read, write or read-modify-write transactions on one of NCH transceiver DRP ports. It generates its own divided DRP clock and applies a ready-timeout. It sits between the PCIe register file and the GT quad(s).

---
 rtl/gt_drp_multi_if.sv | 32 +++
 rtl/gt_drp_multi.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gt_drp_multi_if.sv
// Host command/status and multi-channel DRP bus bundle for gt_drp_multi.
// Latency: n/a (wires only).
// Backpressure: none; DRP ready is per channel, and the host sees busy in status.
// Ports: write/din/dout (host side), drpclock/drp_address/drp_di/drp_we/drp_en
// (DRP master outputs), drp_do/drp_ready (per-channel DRP returns).
interface gt_drp_multi_if #(
    parameter int NCH = 4,
    parameter int AW  = 9
);
    logic              write;
    logic [63:0]       din;
    logic [31:0]       dout;
    logic              drpclock;
    logic [AW-1:0]     drp_address;
    logic [15:0]       drp_di;
    logic              drp_we;
    logic [NCH-1:0]    drp_en;
    logic [16*NCH-1:0] drp_do;
    logic [NCH-1:0]    drp_ready;

    // DRP master side (the bridge itself)
    modport master (
        input  write, din, drp_do, drp_ready,
        output dout, drpclock, drp_address, drp_di, drp_we, drp_en
    );

    // Host plus transceiver side
    modport slave (
        output write, din, drp_do, drp_ready,
        input  dout, drpclock, drp_address, drp_di, drp_we, drp_en
    );
endinterface

// File: rtl/gt_drp_multi.sv
// Multi-channel DRP master: host 64-bit command -> read / write / RMW on one of NCH DRP ports.
// Latency: the DRP strobe starts on the first divided-clock tick after the command; it completes on the ready tick.
// Backpressure: busy in dout[16]; a command arriving while busy is dropped and flagged as overrun.
// Ports: clock, reset (async, active high); bus (master modport):
//   write/din  command strobe and word      dout      status (data, busy, timeout, overrun, bad channel)
//   drpclock   divided DRP clock            drp_*     shared address/data/we and one-hot per-channel enable
module gt_drp_multi #(
    parameter int NCH      = 4,
    parameter int AW       = 9,
    parameter int DIV_LOG2 = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic           clock,
    input  logic           reset,
    gt_drp_multi_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        WR_ISSUE = 2'd2,
        WAIT     = 2'd3
    } state_t;

    state_t            state_q, state_n;
    logic [DIV_LOG2-1:0] div_q;
    logic              tick;

    logic [AW-1:0]     addr_q, addr_n;
    logic [15:0]       wdata_q, wdata_n;   // data to write; replaced by the merged word in RMW
    logic [15:0]       mask_q, mask_n;
    logic [7:0]        ch_q, ch_n;
    logic              rmw_q, rmw_n;
    logic              wr_phase_q, wr_phase_n;
    logic [15:0]       cnt_q, cnt_n;
    logic [NCH-1:0]    en_q, en_n;
    logic              we_q, we_n;
    logic [15:0]       di_q, di_n;
    logic [15:0]       rdata_q, rdata_n;
    logic              tmo_q, tmo_n;
    logic              ovr_q, ovr_n;
    logic              bad_q, bad_n;

    logic [NCH-1:0]    onehot;
    logic              sel_ready;
    logic [15:0]       sel_do;
    logic [15:0]       merged;
    logic [15:0]       cnt_inc;
    logic              unused_din;

    assign tick    = (div_q == '0);
    assign merged  = (sel_do & ~mask_q) | (wdata_q & mask_q);
    assign cnt_inc = cnt_q + 16'd1;

    // Only the latched channel's ready/data are visible; all other ports are ignored.
    always_comb begin
        onehot    = '0;
        sel_ready = 1'b0;
        sel_do    = 16'h0000;
        for (int i = 0; i < NCH; i++) begin
            if (ch_q == 8'(i)) begin
                onehot[i] = 1'b1;
                sel_ready = bus.drp_ready[i];
                sel_do    = bus.drp_do[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_n    = state_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        mask_n     = mask_q;
        ch_n       = ch_q;
        rmw_n      = rmw_q;
        wr_phase_n = wr_phase_q;
        cnt_n      = cnt_q;
        en_n       = en_q;
        we_n       = we_q;
        di_n       = di_q;
        rdata_n    = rdata_q;
        tmo_n      = tmo_q;
        ovr_n      = ovr_q;
        bad_n      = bad_q;

        case (state_q)
            IDLE: begin
                if (bus.write) begin
                    addr_n  = bus.din[16 +: AW];
                    wdata_n = bus.din[15:0];
                    mask_n  = bus.din[63:48];
                    ch_n    = bus.din[39:32];
                    rmw_n   = bus.din[30];
                    tmo_n   = 1'b0;
                    ovr_n   = 1'b0;
                    bad_n   = 1'b0;
                    if ({1'b0, bus.din[39:32]} >= 9'(NCH)) begin
                        bad_n = 1'b1;
                    end else if (bus.din[30] || !bus.din[31]) begin
                        // RMW always starts with a read, whatever the write-enable bit says
                        state_n = RD_ISSUE;
                    end else begin
                        state_n = WR_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (tick) begin
                    en_n       = onehot;
                    we_n       = 1'b0;
                    cnt_n      = 16'd0;
                    wr_phase_n = 1'b0;
                    state_n    = WAIT;
                end
            end
            WR_ISSUE: begin
                if (tick) begin
                    en_n       = onehot;
                    we_n       = 1'b1;
                    di_n       = wdata_q;
                    cnt_n      = 16'd0;
                    wr_phase_n = 1'b1;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                if (tick) begin
                    // The first WAIT tick closes the strobe, so en lasts exactly one DRP clock.
                    en_n = '0;
                    we_n = 1'b0;
                    if (sel_ready) begin
                        if (!wr_phase_q && rmw_q) begin
                            rdata_n = merged;
                            di_n    = merged;
                            wdata_n = merged;
                            state_n = WR_ISSUE;
                        end else begin
                            if (!wr_phase_q) begin
                                rdata_n = sel_do;
                            end
                            state_n = IDLE;
                        end
                    end else if (cnt_inc == 16'(TIMEOUT)) begin
                        tmo_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (bus.write && (state_q != IDLE)) begin
            ovr_n = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= 16'h0000;
            mask_q     <= 16'h0000;
            ch_q       <= 8'h00;
            rmw_q      <= 1'b0;
            wr_phase_q <= 1'b0;
            cnt_q      <= 16'd0;
            en_q       <= '0;
            we_q       <= 1'b0;
            di_q       <= 16'h0000;
            rdata_q    <= 16'h0000;
            tmo_q      <= 1'b0;
            ovr_q      <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            div_q      <= div_q + DIV_LOG2'(1);
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            mask_q     <= mask_n;
            ch_q       <= ch_n;
            rmw_q      <= rmw_n;
            wr_phase_q <= wr_phase_n;
            cnt_q      <= cnt_n;
            en_q       <= en_n;
            we_q       <= we_n;
            di_q       <= di_n;
            rdata_q    <= rdata_n;
            tmo_q      <= tmo_n;
            ovr_q      <= ovr_n;
            bad_q      <= bad_n;
        end
    end

    // Reserved command bits are accepted and ignored.
    assign unused_din = ^bus.din;

    assign bus.dout        = {12'h000, bad_q, ovr_q, tmo_q, (state_q != IDLE), rdata_q};
    assign bus.drpclock    = div_q[DIV_LOG2-1];
    assign bus.drp_address = addr_q;
    assign bus.drp_di      = di_q;
    assign bus.drp_we      = we_q;
    assign bus.drp_en      = en_q;

endmodule
